// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc decode/execute boundary.
package jzjpcc_pkg;

    typedef logic [2:0] aluOperation_t;
    typedef logic [1:0] aluMuxMode_t;
    typedef logic [2:0] funct3_t;

    // Where the destination register value comes from
    localparam logic RD_SOURCE_ALU = 1'b0;
    localparam logic RD_SOURCE_MEM = 1'b1;

    // Execute-stage register contents (PC is kept alongside, its width is per-instance)
    typedef struct packed {
        logic          valid;
        logic          memoryWriteEnable;
        logic          rdSource;
        logic          rdWriteEnable;
        logic          aluMod;
        logic [31:0]   immediate;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [4:0]    rs1Addr;
        logic [4:0]    rs2Addr;
        logic [4:0]    rdAddr;
        aluOperation_t aluOperation;
        aluMuxMode_t   aluMuxMode;
        funct3_t       funct3;
    } deStage_t;

    // A bubble is simply an all-zero stage: not valid, writes nothing
    localparam deStage_t DE_BUBBLE = '0;

endpackage

// File: rtl/jzjpcc_forward_mux.sv
// Operand forwarding: picks the newest value of one source register from
// the memory stage (ALU results only), the writeback stage, or the register.
module jzjpcc_forward_mux
    import jzjpcc_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic [4:0]  regAddr,
    input  logic [31:0] regValue,
    input  logic [4:0]  mRdAddr,
    input  logic        mRdWriteEnable,
    input  logic        mRdSource,
    input  logic [31:0] mAluResult,
    input  logic [4:0]  wRdAddr,
    input  logic        wRdWriteEnable,
    input  logic [31:0] wRdData,
    output logic [31:0] forwarded
);

    // Memory stage wins over writeback; x0 and loads in memory are never forwarded
    always_comb begin
        forwarded = regValue;
        if (FORWARD_EN && (regAddr != 5'd0)) begin
            if (mRdWriteEnable && (mRdSource == RD_SOURCE_ALU) && (mRdAddr == regAddr))
                forwarded = mAluResult;
            else if (wRdWriteEnable && (wRdAddr == regAddr))
                forwarded = wRdData;
        end
    end

endmodule

// File: rtl/jzjpcc_decode_execute_reg.sv
// Decode -> execute pipeline register with stall hold, flush/bubble
// insertion, load-use hazard detection and rs1/rs2 forwarding.
module jzjpcc_decode_execute_reg
    import jzjpcc_pkg::*;
#(
    parameter int PC_MAX_B   = 15,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                d_valid,
    input  logic                d_memoryWriteEnable,
    input  logic                d_rdSource,
    input  logic                d_rdWriteEnable,
    input  logic                d_aluMod,
    input  logic                d_rs1Used,
    input  logic                d_rs2Used,
    input  logic [31:0]         d_immediate,
    input  logic [31:0]         d_rs1,
    input  logic [31:0]         d_rs2,
    input  logic [4:0]          d_rs1Addr,
    input  logic [4:0]          d_rs2Addr,
    input  logic [4:0]          d_rdAddr,
    input  logic [PC_MAX_B:2]   d_currentPC,
    input  logic [2:0]          d_aluOperation,
    input  logic [1:0]          d_aluMuxMode,
    input  logic [2:0]          d_funct3,
    input  logic [4:0]          m_rdAddr,
    input  logic                m_rdWriteEnable,
    input  logic                m_rdSource,
    input  logic [31:0]         m_aluResult,
    input  logic [4:0]          w_rdAddr,
    input  logic                w_rdWriteEnable,
    input  logic [31:0]         w_rdData,
    output logic                e_valid,
    output logic                e_memoryWriteEnable,
    output logic                e_rdSource,
    output logic                e_rdWriteEnable,
    output logic                e_aluMod,
    output logic [31:0]         e_immediate,
    output logic [31:0]         e_rs1,
    output logic [31:0]         e_rs2,
    output logic [4:0]          e_rs1Addr,
    output logic [4:0]          e_rs2Addr,
    output logic [4:0]          e_rdAddr,
    output logic [PC_MAX_B:2]   e_currentPC,
    output logic [2:0]          e_aluOperation,
    output logic [1:0]          e_aluMuxMode,
    output logic [2:0]          e_funct3,
    output logic                loadUseStall
);

    deStage_t           stage;
    deStage_t           decodeIn;
    logic [PC_MAX_B:2]  pcReg;
    logic [31:0]        fwdRs1;
    logic [31:0]        fwdRs2;
    logic               hazard;

    // Gather the decode-side fields into the stage layout
    always_comb begin
        decodeIn                   = DE_BUBBLE;
        decodeIn.valid             = d_valid;
        decodeIn.memoryWriteEnable = d_memoryWriteEnable;
        decodeIn.rdSource          = d_rdSource;
        decodeIn.rdWriteEnable     = d_rdWriteEnable;
        decodeIn.aluMod            = d_aluMod;
        decodeIn.immediate         = d_immediate;
        decodeIn.rs1               = d_rs1;
        decodeIn.rs2               = d_rs2;
        decodeIn.rs1Addr           = d_rs1Addr;
        decodeIn.rs2Addr           = d_rs2Addr;
        decodeIn.rdAddr            = d_rdAddr;
        decodeIn.aluOperation      = d_aluOperation;
        decodeIn.aluMuxMode        = d_aluMuxMode;
        decodeIn.funct3            = d_funct3;
    end

    // A load sitting in execute whose destination the decode instruction reads
    always_comb begin
        hazard = stage.valid && (stage.rdSource == RD_SOURCE_MEM) && stage.rdWriteEnable
              && (stage.rdAddr != 5'd0) && d_valid
              && ((d_rs1Used && (d_rs1Addr == stage.rdAddr))
               || (d_rs2Used && (d_rs2Addr == stage.rdAddr)));
    end

    // Flush and external stall already handle the stage, so they mask the hazard
    assign loadUseStall = hazard && !flush && !stall;

    jzjpcc_forward_mux #(.FORWARD_EN(FORWARD_EN)) forwardRs1 (
        .regAddr        (stage.rs1Addr),
        .regValue       (stage.rs1),
        .mRdAddr        (m_rdAddr),
        .mRdWriteEnable (m_rdWriteEnable),
        .mRdSource      (m_rdSource),
        .mAluResult     (m_aluResult),
        .wRdAddr        (w_rdAddr),
        .wRdWriteEnable (w_rdWriteEnable),
        .wRdData        (w_rdData),
        .forwarded      (fwdRs1)
    );

    jzjpcc_forward_mux #(.FORWARD_EN(FORWARD_EN)) forwardRs2 (
        .regAddr        (stage.rs2Addr),
        .regValue       (stage.rs2),
        .mRdAddr        (m_rdAddr),
        .mRdWriteEnable (m_rdWriteEnable),
        .mRdSource      (m_rdSource),
        .mAluResult     (m_aluResult),
        .wRdAddr        (w_rdAddr),
        .wRdWriteEnable (w_rdWriteEnable),
        .wRdData        (w_rdData),
        .forwarded      (fwdRs2)
    );

    // Stage update: reset > flush > stall (operands absorb forwards) > load-use bubble > load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage <= DE_BUBBLE;
            pcReg <= '0;
        end else if (flush) begin
            stage <= DE_BUBBLE;
            pcReg <= '0;
        end else if (stall) begin
            stage.rs1 <= fwdRs1;
            stage.rs2 <= fwdRs2;
        end else if (loadUseStall) begin
            stage <= DE_BUBBLE;
            pcReg <= '0;
        end else begin
            stage <= decodeIn;
            pcReg <= d_currentPC;
        end
    end

    assign e_valid             = stage.valid;
    assign e_memoryWriteEnable = stage.memoryWriteEnable;
    assign e_rdSource          = stage.rdSource;
    assign e_rdWriteEnable     = stage.rdWriteEnable;
    assign e_aluMod            = stage.aluMod;
    assign e_immediate         = stage.immediate;
    assign e_rs1               = fwdRs1;
    assign e_rs2               = fwdRs2;
    assign e_rs1Addr           = stage.rs1Addr;
    assign e_rs2Addr           = stage.rs2Addr;
    assign e_rdAddr            = stage.rdAddr;
    assign e_currentPC         = pcReg;
    assign e_aluOperation      = stage.aluOperation;
    assign e_aluMuxMode        = stage.aluMuxMode;
    assign e_funct3            = stage.funct3;

endmodule
